conv_pe_unit: RTL and testbench



---
 rtl/conv_pkg.sv | 11 +
 rtl/conv_pe_unit_sat_round.sv | 39 +++
 rtl/conv_pe_unit.sv | 107 ++++++++++
 tb/tb_conv_pe_unit.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// rtl/conv_pkg.sv - shared types and constants for the convolution processing elements
package conv_pkg;

  typedef logic signed [15:0] data_t;

  localparam int FRAC_BITS_DEFAULT = 8;

  localparam data_t SAT_MAX = 16'h7FFF;
  localparam data_t SAT_MIN = 16'h8000;

endpackage

// File: rtl/conv_pe_unit_sat_round.sv
// rtl/conv_pe_unit_sat_round.sv - shift, bias add and 16-bit saturation (ReLU under CONV_PE_RELU_EN)
module sat_round
  import conv_pkg::*;
#(
  parameter int ACC_W     = 37,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic signed [ACC_W-1:0] acc_i,
  input  data_t                   bias_i,
  output data_t                   result_o
);

  logic signed [ACC_W-1:0] shifted;
  logic signed [ACC_W-1:0] sum;
  logic signed [ACC_W-1:0] hi_bound;
  logic signed [ACC_W-1:0] lo_bound;
  data_t                   sat;

  // Drop the fraction (floor), add the bias at full width, then clamp to 16 bits.
  always_comb begin
    shifted  = acc_i >>> FRAC_BITS;
    sum      = shifted + {{(ACC_W-16){bias_i[15]}}, bias_i};
    hi_bound = {{(ACC_W-16){1'b0}}, SAT_MAX};
    lo_bound = {{(ACC_W-16){1'b1}}, SAT_MIN};
    if (sum > hi_bound) begin
      sat = SAT_MAX;
    end else if (sum < lo_bound) begin
      sat = SAT_MIN;
    end else begin
      sat = sum[15:0];
    end
`ifdef CONV_PE_RELU_EN
    result_o = sat[15] ? '0 : sat;
`else
    result_o = sat;
`endif
  end

endmodule

// File: rtl/conv_pe_unit.sv
// rtl/conv_pe_unit.sv - serial Q8.8 MAC processing element (optional ReLU: CONV_PE_RELU_EN)
module conv_pe_unit
  import conv_pkg::*;
#(
  parameter int N         = 25,
  parameter int FRAC_BITS = FRAC_BITS_DEFAULT
) (
  input  logic  clk,
  input  logic  n_reset,
  input  logic  start,
  input  logic  ready_in,
  input  data_t input_featuremap,
  input  data_t weight,
  input  data_t bias,
  output data_t output_featuremap,
  output logic  flag
);

  localparam int ACC_W = 32 + $clog2(N);
  localparam int CNT_W = $clog2(N + 1);
  localparam logic [CNT_W-1:0] CNT_N = CNT_W'(N);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ACC  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]              state_q, state_d;
  logic [CNT_W-1:0]        cnt_q, cnt_d, cnt_inc;
  logic signed [ACC_W-1:0] acc_q, acc_d, acc_sum, prod_ext;
  logic signed [31:0]      fm_ext, wt_ext, prod;
  data_t                   out_q, out_d, result;
  logic                    flag_q, flag_d;

  assign fm_ext   = {{16{input_featuremap[15]}}, input_featuremap};
  assign wt_ext   = {{16{weight[15]}}, weight};
  assign prod     = fm_ext * wt_ext;
  assign prod_ext = ACC_W'(prod);
  assign acc_sum  = acc_q + prod_ext;
  assign cnt_inc  = cnt_q + CNT_W'(1);

  // The result is formed from the sum that includes the final sample, so it can be
  // registered on the same edge that accepts it; flag is then high while in DONE.
  sat_round #(
    .ACC_W    (ACC_W),
    .FRAC_BITS(FRAC_BITS)
  ) u_sat_round (
    .acc_i   (acc_sum),
    .bias_i  (bias),
    .result_o(result)
  );

  // Window sequencing: clear on start, accumulate accepted pairs, publish on the last one.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    out_d   = out_q;
    flag_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          cnt_d   = '0;
          state_d = ST_ACC;
        end
      end
      ST_ACC: begin
        if (ready_in) begin
          acc_d = acc_sum;
          cnt_d = cnt_inc;
          if (cnt_inc == CNT_N) begin
            out_d   = result;
            flag_d  = 1'b1;
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State registers; reset aborts any window in progress and clears the output.
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      out_q   <= '0;
      flag_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      out_q   <= out_d;
      flag_q  <= flag_d;
    end
  end

  assign output_featuremap = out_q;
  assign flag              = flag_q;

endmodule

// File: tb/tb_conv_pe_unit.sv
// tb/tb_conv_pe_unit.sv - randomized self-checking bench for conv_pe_unit
module tb_conv_pe_unit;
  import conv_pkg::*;

  localparam int N = 25;

  logic  clk = 1'b0;
  logic  n_reset = 1'b0;
  logic  start = 1'b0;
  logic  ready_in = 1'b0;
  data_t input_featuremap = '0;
  data_t weight = '0;
  data_t bias = '0;
  data_t output_featuremap;
  logic  flag;

  int pass_cnt = 0;
  int total_cnt = 0;

  data_t fa[N];
  data_t wa[N];

  always #5 clk = ~clk;

  conv_pe_unit #(.N(N)) dut (
    .clk              (clk),
    .n_reset          (n_reset),
    .start            (start),
    .ready_in         (ready_in),
    .input_featuremap (input_featuremap),
    .weight           (weight),
    .bias             (bias),
    .output_featuremap(output_featuremap),
    .flag             (flag)
  );

  // Reference: exact dot product, floor by 2^8, add bias, clamp, optional ReLU.
  function automatic data_t model_result(input data_t b);
    longint s;
    s = 0;
    for (int i = 0; i < N; i++) s += longint'(fa[i]) * longint'(wa[i]);
    s = s >>> 8;
    s = s + longint'(b);
    if (s > 32767) s = 32767;
    if (s < -32768) s = -32768;
`ifdef CONV_PE_RELU_EN
    if (s < 0) s = 0;
`endif
    return data_t'(s[15:0]);
  endfunction

  function automatic data_t rnd_data();
    data_t v;
    v = data_t'($urandom_range(0, 65535));
    return v >>> $urandom_range(0, 8);
  endfunction

  // Start at cycle 0 and feed fa/wa; records when flag was seen relative to cycle 0.
  // gap_mode: 0 ready always, 1 ready every other cycle, 2 random gaps.
  task automatic run_window(input int gap_mode, input bit noise, input int tail,
                            output int flag_cyc, output int flag_cnt, output int idle_cnt,
                            output data_t got_out, output data_t end_out);
    int  idx;
    int  cyc;
    bit  rdy;
    flag_cyc = -1;
    flag_cnt = 0;
    idle_cnt = 0;
    got_out  = 'x;
    @(posedge clk); #1;
    start    = 1'b1;
    ready_in = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    cyc   = 1;
    idx   = 0;
    while (idx < N && cyc < 400) begin
      case (gap_mode)
        0:       rdy = 1'b1;
        1:       rdy = (cyc % 2) == 1;
        default: rdy = $urandom_range(0, 2) != 0;
      endcase
      ready_in = rdy;
      start    = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      if (rdy) begin
        input_featuremap = fa[idx];
        weight           = wa[idx];
        idx++;
      end else begin
        input_featuremap = rnd_data();
        weight           = rnd_data();
        idle_cnt++;
      end
      @(posedge clk); #1;
      cyc++;
      if (flag) begin
        if (flag_cyc < 0) begin
          flag_cyc = cyc;
          got_out  = output_featuremap;
        end
        flag_cnt++;
      end
    end
    ready_in = 1'b0;
    start    = noise;
    for (int t = 0; t < tail; t++) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      if (flag) flag_cnt++;
    end
    start   = 1'b0;
    end_out = output_featuremap;
  endtask

  task automatic test_reset();
    #12;
    total_cnt++;
    if (flag !== 1'b0) $display("FAIL reset_flag: got %b expected 0", flag);
    else pass_cnt++;
    total_cnt++;
    if (output_featuremap !== 16'h0000) $display("FAIL reset_out: got %h expected 0000", output_featuremap);
    else pass_cnt++;
    @(posedge clk); #1;
    n_reset = 1'b1;
  endtask

  task automatic test_all_ones();
    int fc, fn, ic;
    data_t g, e;
    for (int i = 0; i < N; i++) begin fa[i] = 16'h0100; wa[i] = 16'h0100; end
    bias = 16'h0000;
    run_window(0, 1'b0, 3, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== 16'h1900) $display("FAIL ones_out: got %h expected 1900", g);
    else pass_cnt++;
    total_cnt++;
    if (fc != N + 1) $display("FAIL ones_flag_cycle: got %0d expected %0d", fc, N + 1);
    else pass_cnt++;
    total_cnt++;
    if (fn != 1) $display("FAIL ones_flag_width: got %0d expected 1", fn);
    else pass_cnt++;
    total_cnt++;
    if (e !== 16'h1900) $display("FAIL ones_hold: got %h expected 1900", e);
    else pass_cnt++;
  endtask

  task automatic test_bias_gaps();
    int fc, fn, ic;
    data_t g, e;
    for (int i = 0; i < N; i++) begin fa[i] = 16'h0080; wa[i] = 16'h0200; end
    bias = 16'hFF00;
    run_window(1, 1'b0, 2, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== 16'h1800) $display("FAIL gaps_out: got %h expected 1800", g);
    else pass_cnt++;
    total_cnt++;
    if (fc != N + 1 + ic || ic == 0) $display("FAIL gaps_flag_cycle: got %0d expected %0d (idle %0d)", fc, N + 1 + ic, ic);
    else pass_cnt++;
    total_cnt++;
    if (fn != 1) $display("FAIL gaps_flag_width: got %0d expected 1", fn);
    else pass_cnt++;
  endtask

  task automatic test_negative();
    int fc, fn, ic;
    data_t g, e, exp_v;
    for (int i = 0; i < N; i++) begin fa[i] = 16'h8000; wa[i] = 16'h0100; end
    bias = 16'h0000;
`ifdef CONV_PE_RELU_EN
    exp_v = 16'h0000;
`else
    exp_v = 16'h8000;
`endif
    run_window(2, 1'b1, 2, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== exp_v) $display("FAIL negative_out: got %h expected %h", g, exp_v);
    else pass_cnt++;
    total_cnt++;
    if (fc != N + 1 + ic) $display("FAIL negative_flag_cycle: got %0d expected %0d", fc, N + 1 + ic);
    else pass_cnt++;
  endtask

  task automatic test_pos_sat();
    int fc, fn, ic;
    data_t g, e;
    for (int i = 0; i < N; i++) begin fa[i] = 16'h7FFF; wa[i] = 16'h7FFF; end
    bias = 16'h0000;
    run_window(2, 1'b1, 2, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== 16'h7FFF) $display("FAIL possat_out: got %h expected 7fff", g);
    else pass_cnt++;
    total_cnt++;
    if (fn != 1) $display("FAIL possat_flag_width: got %0d expected 1", fn);
    else pass_cnt++;
  endtask

  task automatic test_random();
    int fc, fn, ic;
    data_t g, e, exp_v;
    for (int w = 0; w < 8; w++) begin
      for (int i = 0; i < N; i++) begin fa[i] = rnd_data(); wa[i] = rnd_data(); end
      bias  = rnd_data();
      exp_v = model_result(bias);
      run_window(2, 1'b1, 2, fc, fn, ic, g, e);
      total_cnt++;
      if (g !== exp_v) $display("FAIL random_out[%0d]: got %h expected %h", w, g, exp_v);
      else pass_cnt++;
      total_cnt++;
      if (fc != N + 1 + ic || fn != 1) $display("FAIL random_flag[%0d]: got cycle %0d count %0d expected cycle %0d count 1", w, fc, fn, N + 1 + ic);
      else pass_cnt++;
    end
  endtask

  task automatic test_reset_mid();
    int fc, fn, ic, flags;
    data_t g, e;
    @(posedge clk); #1;
    start = 1'b1;
    @(posedge clk); #1;
    start    = 1'b0;
    ready_in = 1'b1;
    input_featuremap = 16'h0100;
    weight           = 16'h0100;
    repeat (10) @(posedge clk);
    #1;
    n_reset = 1'b0;
    #1;
    total_cnt++;
    if (flag !== 1'b0) $display("FAIL midreset_flag: got %b expected 0", flag);
    else pass_cnt++;
    total_cnt++;
    if (output_featuremap !== 16'h0000) $display("FAIL midreset_out: got %h expected 0000", output_featuremap);
    else pass_cnt++;
    @(posedge clk); #1;
    n_reset = 1'b1;
    flags = 0;
    repeat (N + 4) begin
      @(posedge clk); #1;
      if (flag) flags++;
    end
    ready_in = 1'b0;
    total_cnt++;
    if (flags != 0) $display("FAIL midreset_no_flag: got %0d flags expected 0", flags);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin fa[i] = 16'h0100; wa[i] = 16'h0100; end
    bias = 16'h0000;
    run_window(0, 1'b0, 2, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== 16'h1900 || fc != N + 1) $display("FAIL midreset_fresh: got %h at cycle %0d expected 1900 at cycle %0d", g, fc, N + 1);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    int fc, fn, ic;
    data_t g, e, exp_a, exp_b;
    for (int i = 0; i < N; i++) begin fa[i] = rnd_data(); wa[i] = rnd_data(); end
    bias  = rnd_data();
    exp_a = model_result(bias);
    run_window(0, 1'b0, 0, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== exp_a || fc != N + 1) $display("FAIL b2b_first: got %h at cycle %0d expected %h at cycle %0d", g, fc, exp_a, N + 1);
    else pass_cnt++;
    for (int i = 0; i < N; i++) begin fa[i] = rnd_data(); wa[i] = rnd_data(); end
    bias  = rnd_data();
    exp_b = model_result(bias);
    run_window(0, 1'b0, 2, fc, fn, ic, g, e);
    total_cnt++;
    if (g !== exp_b || fc != N + 1) $display("FAIL b2b_second: got %h at cycle %0d expected %h at cycle %0d", g, fc, exp_b, N + 1);
    else pass_cnt++;
    total_cnt++;
    if (fn != 1 || e !== exp_b) $display("FAIL b2b_hold: got count %0d out %h expected count 1 out %h", fn, e, exp_b);
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_all_ones();
    test_bias_gaps();
    test_negative();
    test_random();
    test_pos_sat();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout: got no completion expected finish");
    $fatal(1, "timeout");
  end

endmodule
